lc3_pipeline_ctrl: RTL and testbench
====================================

# lc3_pipeline_ctrl

Central sequencing controller for the LC3 five-stage pipeline (fetch, decode, execute, memory, writeback). It generates the per-stage enable strobes and tracks pipeline fill. It stalls the pipeline for data-memory accesses (including the two-phase LDI/STI indirection) and for branch/JMP resolution, and flushes the front end on a taken branch. The decode stage's IR output and the execute stage's IR_Exec feed it; its enables drive every stage.

## Interface
Parameters: none.

- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-low (asserted when 0)
- complete_instr  in  1  instruction memory has valid data this cycle
- complete_data  in  1  data memory access finishes this cycle
- IR  in  16  decode-stage instruction, i.e. the instruction entering execute
- IR_Exec  in  16  instruction currently held in execute
- NZP  in  3  condition codes from writeback: N=bit2, Z=bit1, P=bit0
- enable_fetch  out  1  fetch-stage advance
- enable_updatePC  out  1  PC register load
- enable_decode  out  1  decode-stage advance
- enable_execute  out  1  execute-stage advance
- enable_writeback  out  1  register-file write strobe
- mem_state  out  2  0=read, 1=write, 2=indirect-address read, 3=idle
- br_taken  out  1  PC loads branch/JMP target (qualifies enable_updatePC)

## Operation
- Opcode is IR[15:12]:
  - ALU-with-writeback: ADD 0001, AND 0101, NOT 1001, LEA 1110.
  - Load: LD 0010, LDR 0110, LDI 1010.
  - Store: ST 0011, STR 0111, STI 1011.
  - Control: BR 0000, JMP 1100.
  - All other opcodes behave as NOP (no memory access, no writeback, no branch).
- States: RUN, MEM_IND, MEM_RD, MEM_WR, BR_WAIT, BR_RES.
- Fill counter fc (2 bits, saturates at 3). It increments on every RUN cycle with complete_instr=1.
- In RUN, with adv = complete_instr:
  - enable_fetch = enable_updatePC = adv.
  - enable_decode = adv & (fc≥1).
  - enable_execute = adv & (fc≥2).
  - br_taken = 0; mem_state = 3.
- On enable_execute=1, the controller latches the opcode class of IR and sets the next state:
  - LD/LDR → MEM_RD.
  - ST/STR → MEM_WR.
  - LDI/STI → MEM_IND; the latched flag records the second phase (rd or wr).
  - BR/JMP → BR_WAIT.
  - ALU-with-writeback → stay in RUN and set wb_pending.
  - Otherwise → stay in RUN.
- wb_pending is a register. enable_writeback = wb_pending | ld_done, where ld_done is registered and set on the MEM_RD cycle with complete_data=1.
- MEM_IND: mem_state=2. All stage enables are 0. On complete_data, go to MEM_RD (LDI) or MEM_WR (STI).
- MEM_RD: mem_state=0, enables 0. On complete_data, go to RUN and set ld_done.
- MEM_WR: mem_state=1, enables 0. On complete_data, go to RUN; no writeback.
- BR_WAIT: one cycle with all enables 0. It lets the prior instruction's writeback update NZP. Always goes to BR_RES.
- BR_RES: one cycle.
  - br_taken = 1 for JMP; br_taken = |(IR_Exec[11:9] & NZP) for BR.
  - enable_updatePC = br_taken; all other enables 0; mem_state = 3.
  - Next state is RUN.
  - If taken, fc ← 0, which flushes the wrong-path decode/fetch contents. If not taken, fc is unchanged.
- complete_data is ignored outside memory states. complete_instr is ignored outside RUN.

## Timing
- Reset (rst=0 at an edge), from any state including mid-memory or mid-branch:
  - Next cycle: state=RUN, fc=0, wb_pending=0, ld_done=0.
  - All enables 0, br_taken=0, mem_state=3.
  - During reset cycles, all enables are forced to 0.
- All outputs are functions of registered state and same-cycle inputs (complete_instr, IR, IR_Exec, NZP). There is no output register delay beyond the state.
- Pipeline fill after reset release, with complete_instr held at 1:
  - Cycle 1: enable_fetch only.
  - Cycle 2: adds enable_decode.
  - Cycle 3 onward: adds enable_execute.
- Writeback latency: enable_writeback pulses exactly 1 cycle after enable_execute for an ALU op. It pulses exactly 1 cycle after the completing MEM_RD cycle for a load.
- A wb_pending and an ld_done pulse can never coincide, because enable_execute is 0 throughout memory states.
- Memory stall length = number of cycles until complete_data, with a minimum of 1 cycle per phase.
- Branch penalty: 2 cycles (BR_WAIT, BR_RES). A taken branch then re-fills: enable_decode returns 1 cycle and enable_execute 2 cycles after RUN resumes.
- complete_instr=0 in RUN freezes all enables and fc for that cycle.

## Test plan
- Reset/fill: hold rst=0 for 3 cycles → all enables 0, mem_state=3. Release with complete_instr=1 → fetch in cycle 1, decode from cycle 2, execute from cycle 3.
- ALU stream: ADD (IR=16'h1261) enters execute → enable_writeback=1 exactly next cycle. With complete_instr toggling 1,0,1, enables drop in the 0 cycle and fc holds.
- LDR (16'h6642) with complete_data on the 3rd memory cycle → 3 cycles of mem_state=0 with all enables 0 → RUN, with enable_writeback=1 in the first RUN cycle.
- STI (16'hB605) → mem_state=2 until complete_data (2 cycles), then mem_state=1 until complete_data (1 cycle), then RUN. enable_writeback is never asserted.
- Branches:
  - BRz (16'h0403) with NZP=3'b010 → BR_RES has br_taken=1, enable_updatePC=1; the next RUN cycle has enable_decode=0.
  - BRn (16'h0803) with NZP=3'b010 → br_taken=0, enable_updatePC=0, and the pipeline resumes with fc intact.
  - JMP → always taken.
- Reset mid-MEM_RD: rst=0 for 1 cycle before complete_data → next cycle mem_state=3 and all enables 0. A later complete_data=1 produces no writeback.

Source files
------------

// File: rtl/lc3_pipeline_ctrl.sv
// lc3_pipeline_ctrl: stage enables, fill tracking and memory/branch stalls for the LC3 pipeline
module lc3_pipeline_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  NZP,
  output logic        enable_fetch,
  output logic        enable_updatePC,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic [1:0]  mem_state,
  output logic        br_taken
);
  typedef enum logic [2:0] {RUN, MEM_IND, MEM_RD, MEM_WR, BR_WAIT, BR_RES} state_t;
  state_t state, state_nx;
  logic [1:0] fc;
  logic wb_pending, ld_done, ind_wr, is_jmp;
  logic [3:0] op;
  logic adv, taken, alu, unused_bits;
  always_comb begin
    op = IR[15:12];
    alu = op == 4'h1 || op == 4'h5 || op == 4'h9 || op == 4'hE;
    adv = rst && state == RUN && complete_instr;
    taken = is_jmp || |(IR_Exec[11:9] & NZP);
    enable_fetch = adv;
    enable_decode = adv && fc != 2'd0;
    enable_execute = adv && fc[1];
    br_taken = rst && state == BR_RES && taken;
    enable_updatePC = adv || br_taken;
    enable_writeback = rst && (wb_pending || ld_done);
    mem_state = !rst ? 2'd3 : state == MEM_IND ? 2'd2 : state == MEM_RD ? 2'd0 :
                state == MEM_WR ? 2'd1 : 2'd3;
    unused_bits = ^{IR[11:0], IR_Exec[15:12], IR_Exec[8:0]};
  end
  always_comb begin
    state_nx = state;
    case (state)
      RUN: if (enable_execute)
        state_nx = (op == 4'h2 || op == 4'h6) ? MEM_RD :
                   (op == 4'h3 || op == 4'h7) ? MEM_WR :
                   (op == 4'hA || op == 4'hB) ? MEM_IND :
                   (op == 4'h0 || op == 4'hC) ? BR_WAIT : RUN;
      MEM_IND: if (complete_data) state_nx = ind_wr ? MEM_WR : MEM_RD;
      MEM_RD, MEM_WR: if (complete_data) state_nx = RUN;
      BR_WAIT: state_nx = BR_RES;
      default: state_nx = RUN;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= RUN;
      fc <= 2'd0;
      wb_pending <= 1'b0;
      ld_done <= 1'b0;
      ind_wr <= 1'b0;
      is_jmp <= 1'b0;
    end else begin
      state <= state_nx;
      wb_pending <= enable_execute && alu;
      ld_done <= state == MEM_RD && complete_data;
      if (enable_execute) begin
        ind_wr <= op == 4'hB;
        is_jmp <= op == 4'hC;
      end
      if (adv && fc != 2'd3) fc <= fc + 2'd1;
      else if (br_taken) fc <= 2'd0;
    end
endmodule

// File: tb/tb_lc3_pipeline_ctrl.sv
// tb_lc3_pipeline_ctrl: directed vectors checked against a phase-queue model of the controller
module tb_lc3_pipeline_ctrl;
  logic clk = 1'b0;
  logic rst, ci, cd;
  logic [15:0] ir, ir_exec;
  logic [2:0] nzp;
  logic ef, epc, edec, eexe, ewb, bt;
  logic [1:0] ms;
  logic [7:0] dut_o;
  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  localparam int PH_IND = 0, PH_RD = 1, PH_WR = 2, PH_WAIT = 3, PH_RES = 4;
  localparam logic [15:0] NOP = 16'hD000;
  int ph_q[$];
  int m_fc = 0;
  bit m_wb = 1'b0, m_ldwb = 1'b0, m_jmp = 1'b0;

  lc3_pipeline_ctrl dut (
    .clk(clk), .rst(rst), .complete_instr(ci), .complete_data(cd),
    .IR(ir), .IR_Exec(ir_exec), .NZP(nzp),
    .enable_fetch(ef), .enable_updatePC(epc), .enable_decode(edec),
    .enable_execute(eexe), .enable_writeback(ewb), .mem_state(ms), .br_taken(bt)
  );

  assign dut_o = {ef, epc, edec, eexe, ewb, bt, ms};
  always #5 clk = ~clk;

  function automatic bit is_alu(logic [3:0] o);
    return o == 4'h1 || o == 4'h5 || o == 4'h9 || o == 4'hE;
  endfunction

  // Expected {fetch, updatePC, decode, execute, writeback, br_taken, mem_state}
  function automatic logic [7:0] model_out();
    logic f, p, d, x, b;
    logic [1:0] m;
    f = 1'b0; p = 1'b0; d = 1'b0; x = 1'b0; b = 1'b0; m = 2'd3;
    if (!rst) return 8'h03;
    if (ph_q.size() == 0) begin
      f = ci; p = ci; d = ci && m_fc >= 1; x = ci && m_fc >= 2;
    end else begin
      case (ph_q[0])
        PH_IND: m = 2'd2;
        PH_RD: m = 2'd0;
        PH_WR: m = 2'd1;
        PH_RES: begin b = m_jmp || ((ir_exec[11:9] & nzp) != 3'b000); p = b; end
        default: ;
      endcase
    end
    return {f, p, d, x, m_wb || m_ldwb, b, m};
  endfunction

  always @(posedge clk) begin
    logic [7:0] e;
    e = model_out();
    if (!rst) begin
      m_fc = 0; ph_q.delete(); m_wb = 1'b0; m_ldwb = 1'b0;
    end else begin
      m_ldwb = ph_q.size() != 0 && ph_q[0] == PH_RD && cd;
      m_wb = e[4] && is_alu(ir[15:12]);
      if (ph_q.size() == 0) begin
        if (ci && m_fc < 3) m_fc++;
        if (e[4]) begin
          m_jmp = ir[15:12] == 4'hC;
          case (ir[15:12])
            4'h2, 4'h6: ph_q.push_back(PH_RD);
            4'h3, 4'h7: ph_q.push_back(PH_WR);
            4'hA: begin ph_q.push_back(PH_IND); ph_q.push_back(PH_RD); end
            4'hB: begin ph_q.push_back(PH_IND); ph_q.push_back(PH_WR); end
            4'h0, 4'hC: begin ph_q.push_back(PH_WAIT); ph_q.push_back(PH_RES); end
            default: ;
          endcase
        end
      end else begin
        case (ph_q[0])
          PH_WAIT: void'(ph_q.pop_front());
          PH_RES: begin if (e[2]) m_fc = 0; void'(ph_q.pop_front()); end
          default: if (cd) void'(ph_q.pop_front());
        endcase
      end
    end
  end

  always @(negedge clk)
    if (chk_on) begin
      vectors++;
      if (dut_o !== model_out()) begin
        miscompares++;
        $display("FAIL cycle t=%0t: dut=%h model=%h", $time, dut_o, model_out());
      end
    end

  task automatic drive(logic r, logic c_i, logic c_d, logic [15:0] i, logic [15:0] ie, logic [2:0] n);
    @(posedge clk);
    #1;
    rst = r; ci = c_i; cd = c_d; ir = i; ir_exec = ie; nzp = n;
  endtask

  task automatic v(string nm, logic r, logic c_i, logic c_d, logic [15:0] i, logic [15:0] ie,
                   logic [2:0] n, logic [7:0] want);
    drive(r, c_i, c_d, i, ie, n);
    #2;
    vectors++;
    if (dut_o !== want) begin
      miscompares++;
      $display("FAIL %s: dut=%h want=%h", nm, dut_o, want);
    end
    vectors++;
    if (model_out() !== want) begin
      miscompares++;
      $display("FAIL %s model: got=%h want=%h", nm, model_out(), want);
    end
  endtask

  initial begin
    rst = 1'b0; ci = 1'b1; cd = 1'b0; ir = NOP; ir_exec = NOP; nzp = 3'b000;
    @(posedge clk);
    chk_on = 1'b1;
    for (int k = 0; k < 3; k++) v("reset_hold", 0, 1, 0, NOP, NOP, 3'b000, 8'h03);
    v("fill_c1", 1, 1, 0, NOP, NOP, 3'b000, 8'hC3);
    v("fill_c2", 1, 1, 0, NOP, NOP, 3'b000, 8'hE3);
    v("fill_c3", 1, 1, 0, NOP, NOP, 3'b000, 8'hF3);
    v("add_exec", 1, 1, 0, 16'h1261, NOP, 3'b000, 8'hF3);
    v("add_wb_ci0", 1, 0, 0, NOP, 16'h1261, 3'b000, 8'h0B);
    v("ci1_resume", 1, 1, 0, NOP, NOP, 3'b000, 8'hF3);
    v("ldr_exec", 1, 1, 0, 16'h6642, NOP, 3'b000, 8'hF3);
    v("ldr_rd1", 1, 1, 0, NOP, 16'h6642, 3'b000, 8'h00);
    v("ldr_rd2", 1, 1, 0, NOP, 16'h6642, 3'b000, 8'h00);
    v("ldr_rd3", 1, 1, 1, NOP, 16'h6642, 3'b000, 8'h00);
    v("ldr_wb", 1, 1, 0, NOP, NOP, 3'b000, 8'hFB);
    v("sti_exec", 1, 1, 0, 16'hB605, NOP, 3'b000, 8'hF3);
    v("sti_ind1", 1, 1, 0, NOP, 16'hB605, 3'b000, 8'h02);
    v("sti_ind2", 1, 1, 1, NOP, 16'hB605, 3'b000, 8'h02);
    v("sti_wr", 1, 1, 1, NOP, 16'hB605, 3'b000, 8'h01);
    v("sti_run", 1, 1, 0, NOP, NOP, 3'b000, 8'hF3);
    v("brz_exec", 1, 1, 0, 16'h0403, NOP, 3'b010, 8'hF3);
    v("brz_wait", 1, 1, 0, NOP, 16'h0403, 3'b010, 8'h03);
    v("brz_res", 1, 1, 0, NOP, 16'h0403, 3'b010, 8'h47);
    v("brz_refill1", 1, 1, 0, NOP, NOP, 3'b010, 8'hC3);
    v("brz_ci0", 1, 0, 0, NOP, NOP, 3'b010, 8'h03);
    v("brz_refill2", 1, 1, 0, NOP, NOP, 3'b010, 8'hE3);
    v("brz_refill3", 1, 1, 0, NOP, NOP, 3'b010, 8'hF3);
    v("brn_exec", 1, 1, 0, 16'h0803, NOP, 3'b010, 8'hF3);
    v("brn_wait", 1, 1, 0, NOP, 16'h0803, 3'b010, 8'h03);
    v("brn_res", 1, 1, 0, NOP, 16'h0803, 3'b010, 8'h03);
    v("brn_run", 1, 1, 0, NOP, NOP, 3'b010, 8'hF3);
    v("jmp_exec", 1, 1, 0, 16'hC1C0, NOP, 3'b000, 8'hF3);
    v("jmp_wait", 1, 1, 0, NOP, 16'hC1C0, 3'b000, 8'h03);
    v("jmp_res", 1, 1, 0, NOP, 16'hC1C0, 3'b000, 8'h47);
    v("jmp_refill1", 1, 1, 0, NOP, NOP, 3'b000, 8'hC3);
    v("jmp_refill2", 1, 1, 0, NOP, NOP, 3'b000, 8'hE3);
    v("jmp_refill3", 1, 1, 0, NOP, NOP, 3'b000, 8'hF3);
    v("ld_exec", 1, 1, 0, 16'h2201, NOP, 3'b000, 8'hF3);
    v("ld_rd1", 1, 1, 0, NOP, 16'h2201, 3'b000, 8'h00);
    v("ld_reset", 0, 1, 0, NOP, 16'h2201, 3'b000, 8'h03);
    v("post_rst_c1", 1, 1, 1, NOP, NOP, 3'b000, 8'hC3);
    v("post_rst_c2", 1, 1, 1, NOP, NOP, 3'b000, 8'hE3);
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < 4; j++)
        drive(1, 1, 1, {k[3:0], 12'hE25}, {k[3:0], 12'hE25}, 3'b001);
    drive(1, 1, 0, NOP, NOP, 3'b000);
    drive(1, 1, 0, NOP, NOP, 3'b000);
    @(posedge clk);
    #2;
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
